// File: rtl/tt_stim_seq.sv
// Truth-table stimulus sequencer: walks a..d through 0..15, holding each vector DWELL cycles.
// Define TT_CAPTURE_EN to build the response capture registers; otherwise tt_f1/tt_f2 read as zero.
module tt_stim_seq #(
  parameter int DWELL = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        hold,
  input  logic        f1_in,
  input  logic        f2_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        vec_valid,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt_f1,
  output logic [15:0] tt_f2
);

  // state | meaning
  // IDLE  | waiting for start, outputs quiet, tables retained
  // RUN   | presenting vector idx, dwell counter advancing unless held
  // DONE  | one-cycle completion pulse, then back to IDLE
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [7:0] TC = 8'(DWELL - 1);

  logic [1:0] state;
  logic [3:0] idx;
  logic [7:0] cnt;
  logic       accept;
  logic       sample;

  assign accept = (state == IDLE) && start;
  assign sample = (state == RUN) && !hold && (cnt == TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 4'd0;
      cnt       <= 8'd0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            idx       <= 4'd0;
            cnt       <= 8'd0;
            vec_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (!hold) begin
            if (cnt == TC) begin
              cnt <= 8'd0;
              // idx returns to zero on the last vector so a..d read 0000 in DONE
              if (idx == 4'hF) begin
                state     <= DONE;
                idx       <= 4'd0;
                vec_valid <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
              end else begin
                idx <= idx + 4'd1;
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign {a, b, c, d} = idx;

`ifdef TT_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_f1 <= 16'h0000;
      tt_f2 <= 16'h0000;
    end else if (accept) begin
      tt_f1 <= 16'h0000;
      tt_f2 <= 16'h0000;
    end else if (sample) begin
      tt_f1[idx] <= f1_in;
      tt_f2[idx] <= f2_in;
    end
  end
`else
  logic unused_resp;
  assign unused_resp = f1_in ^ f2_in ^ accept ^ sample;
  assign tt_f1 = 16'h0000;
  assign tt_f2 = 16'h0000;
`endif

endmodule

// File: tb/tb_tt_stim_seq.sv
// Scoreboarded bench for tt_stim_seq: DWELL=4 unit with random hold/start traffic,
// plus a free-running DWELL=1 unit with start tied high.
module tb_tt_stim_seq;

  localparam int DW = 4;
`ifdef TT_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic hold = 1'b0;
  logic start1 = 1'b1;
  logic hold1 = 1'b0;
  logic a, b, c, d, vec_valid, busy, done;
  logic [15:0] tt_f1, tt_f2;
  logic a1, b1, c1, d1, vv1, busy1, done1;
  logic [15:0] t1_f1, t1_f2;
  logic [15:0] fn1 = 16'h0000;
  logic [15:0] fn2 = 16'h0000;
  logic f1_in, f2_in, p1_in, q1_in;

  always #5 clk = ~clk;

  // downstream combinational stages
  assign f1_in = fn1[{a, b, c, d}];
  assign f2_in = fn2[{a, b, c, d}];
  assign p1_in = a1 ^ b1 ^ c1 ^ d1;
  assign q1_in = c1 | d1;

  tt_stim_seq #(.DWELL(DW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
    .f1_in(f1_in), .f2_in(f2_in),
    .a(a), .b(b), .c(c), .d(d),
    .vec_valid(vec_valid), .busy(busy), .done(done),
    .tt_f1(tt_f1), .tt_f2(tt_f2)
  );

  tt_stim_seq #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .hold(hold1),
    .f1_in(p1_in), .f2_in(q1_in),
    .a(a1), .b(b1), .c(c1), .d(d1),
    .vec_valid(vv1), .busy(busy1), .done(done1),
    .tt_f1(t1_f1), .tt_f2(t1_f2)
  );

  typedef struct { logic [3:0] v; int dur; } vexp_t;
  typedef struct { logic [15:0] f1; logic [15:0] f2; } texp_t;

  vexp_t vq[$];
  texp_t tq[$];
  int n_vec = 0;
  int n_bad = 0;
  int flush_req = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_abort();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_vec", 32'({a, b, c, d}), 0);
    chk("rst_valid", 32'(vec_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tt", 32'({tt_f1, tt_f2}), 0);
    vq.delete();
    tq.delete();
    flush_req++;
    start = 1'b0;
    hold = 1'b0;
    #1 rst_n = 1'b1;
    repeat (8) step();
  endtask

  // mode: 0 random hold, 1 no hold, 2 ten-cycle hold inside vector 5, 3 reset during vector 9
  task automatic sweep(input int mode, input bit keep, input logic [15:0] g1, input logic [15:0] g2);
    int prog = 0;
    int cyc = 0;
    int last = 0;
    int hrun = 0;
    vexp_t e;
    texp_t t;
    fn1 = g1;
    fn2 = g2;
    t.f1 = CAP ? g1 : 16'h0000;
    t.f2 = CAP ? g2 : 16'h0000;
    tq.push_back(t);
    start = 1'b1;
    hold = 1'($urandom_range(0, 1));
    step();
    while (prog < 16 * DW) begin
      case (mode)
        0: hold = ($urandom_range(0, 3) == 0);
        2: begin
          hold = (prog == 5 * DW + 1) && (hrun < 10);
          if (hold) hrun++;
        end
        default: hold = 1'b0;
      endcase
      start = keep ? 1'b1 : ((mode == 1) ? 1'b0 : 1'($urandom_range(0, 1)));
      if (mode == 3 && prog == 9 * DW + 1) begin
        do_abort();
        return;
      end
      step();
      cyc++;
      if (!hold) begin
        prog++;
        if (prog % DW == 0) begin
          e.v = 4'(prog / DW - 1);
          e.dur = cyc - last;
          vq.push_back(e);
          last = cyc;
        end
      end
    end
    start = keep ? 1'b1 : 1'($urandom_range(0, 1));
    hold = 1'($urandom_range(0, 1));
    step();
    if (!keep) begin
      start = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        hold = 1'($urandom_range(0, 1));
        step();
      end
    end
  endtask

  // monitor / scoreboard
  int flush_seen = 0;
  logic [3:0] run_vec = 4'd0;
  int run_len = 0;
  bit run_on = 1'b0;
  bit prev_valid = 1'b0;
  bit prev_done = 1'b0;
  logic [15:0] last_f1 = 16'h0000;
  logic [15:0] last_f2 = 16'h0000;
  logic [3:0] mv;
  vexp_t me;
  texp_t mt;
  logic [3:0] e1 = 4'd0;
  int since1 = 0;
  bit seen1 = 1'b0;

  always @(negedge clk) begin
    if (flush_seen != flush_req) begin
      flush_seen = flush_req;
      run_on = 1'b0;
      prev_valid = 1'b0;
      prev_done = 1'b0;
      last_f1 = 16'h0000;
      last_f2 = 16'h0000;
      e1 = 4'd0;
      seen1 = 1'b0;
      since1 = 0;
    end
    if (rst_n) begin
      mv = {a, b, c, d};
      if (run_on && (!vec_valid || mv != run_vec)) begin
        if (vq.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL vec_unexpected: got vector %0d for %0d cycles, none expected", run_vec, run_len);
        end else begin
          me = vq.pop_front();
          chk("vec_value", 32'(run_vec), 32'(me.v));
          chk("vec_dwell", run_len, me.dur);
        end
        if (!vec_valid) run_on = 1'b0;
      end
      if (vec_valid && (!run_on || mv != run_vec)) begin
        run_on = 1'b1;
        run_vec = mv;
        run_len = 0;
        if (mv == 4'd0) chk("tt_clear", 32'({tt_f1, tt_f2}), 0);
      end
      if (vec_valid) begin
        run_len++;
        chk("busy_run", 32'(busy), 1);
      end
      if (prev_valid && !vec_valid) chk("done_at_end", 32'(done), 1);
      if (done) begin
        chk("done_width", 32'(prev_done), 0);
        if (tq.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL done_unexpected: got done pulse, none expected (t=%0t)", $time);
        end else begin
          mt = tq.pop_front();
          chk("tt_f1", 32'(tt_f1), 32'(mt.f1));
          chk("tt_f2", 32'(tt_f2), 32'(mt.f2));
          last_f1 = mt.f1;
          last_f2 = mt.f2;
        end
        chk("done_vec", 32'(mv), 0);
        chk("done_busy", 32'(busy), 0);
      end
      if (!busy) begin
        chk("tt_f1_retain", 32'(tt_f1), 32'(last_f1));
        chk("tt_f2_retain", 32'(tt_f2), 32'(last_f2));
      end
      prev_valid = vec_valid;
      prev_done = done;

      since1++;
      if (vv1) begin
        if (e1 == 4'd0) chk("d1_clear", 32'({t1_f1, t1_f2}), 0);
        chk("d1_vec", 32'({a1, b1, c1, d1}), 32'(e1));
        e1 = e1 + 4'd1;
      end
      if (done1) begin
        if (seen1) chk("d1_period", since1, 18);
        seen1 = 1'b1;
        since1 = 0;
        chk("d1_tt_f1", 32'(t1_f1), CAP ? 32'h6996 : 0);
        chk("d1_tt_f2", 32'(t1_f2), CAP ? 32'hEEEE : 0);
        chk("d1_done_valid", 32'(vv1), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] g1, g2;
    #3;
    chk("reset_vec", 32'({a, b, c, d}), 0);
    chk("reset_valid", 32'(vec_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_tt", 32'({tt_f1, tt_f2}), 0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++) begin
      g1[i] = (i >= 12);
      g2[i] = (i % 4) != 0;
    end
    sweep(1, 1'b0, g1, g2);
    sweep(2, 1'b0, 16'($urandom), 16'($urandom));
    repeat (4) sweep(0, 1'b0, 16'($urandom), 16'($urandom));
    sweep(0, 1'b1, 16'($urandom), 16'($urandom));
    sweep(0, 1'b1, 16'($urandom), 16'($urandom));
    sweep(0, 1'b0, 16'($urandom), 16'($urandom));
    sweep(3, 1'b0, 16'($urandom), 16'($urandom));
    sweep(1, 1'b0, 16'($urandom), 16'($urandom));
    repeat (5) step();

    chk("vq_leftover", vq.size(), 0);
    chk("tq_leftover", tq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tt_stim_seq.md
TT_STIM_SEQ -- requirements
Module: tt_stim_seq

Interface
REQ-001 The block SHALL have parameter DWELL, default 20, meaning clock cycles each input vector is held (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1, a request to begin a full 16-vector sweep.
REQ-005 The block SHALL have port hold, input, 1, which pauses the sweep while high.
REQ-006 The block SHALL have ports f1_in and f2_in, input, 1 each, the responses from the downstream 4-input combinational stage.
REQ-007 The block SHALL have ports a, b, c and d, output, 1 each, the registered stimulus vector, with a as MSB.
REQ-008 The block SHALL have port vec_valid, output, 1, high while a..d carry a sweep vector.
REQ-009 The block SHALL have port busy, output, 1, high in RUN.
REQ-010 The block SHALL have port done, output, 1, a one-cycle sweep-complete pulse.
REQ-011 The block SHALL have ports tt_f1 and tt_f2, output, 16 each, the captured truth tables, where bit i is the response to vector i.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
- IDLE -> RUN on start=1.
- RUN -> DONE after vector 15 is sampled.
- DONE -> IDLE unconditionally after 1 cycle.
REQ-013 start sampled high in IDLE at edge k SHALL, at edge k, set idx=0, the dwell counter to 0, {a,b,c,d}=4'b0000, vec_valid=1 and busy=1, and clear tt_f1 and tt_f2 to 0.
REQ-014 In RUN, {a,b,c,d} SHALL equal idx (4 bits), in the order 0000 to 1111 ascending.
- The 8-bit dwell counter increments each non-held cycle.
- On the cycle the counter equals DWELL-1, f1_in and f2_in SHALL be written into bit idx of tt_f1 and tt_f2.
- On that same edge, the counter resets to 0 and idx increments.
REQ-015 With no hold, RUN SHALL last exactly 16*DWELL cycles, and done SHALL be high for the single cycle starting at edge k+16*DWELL.
REQ-016 In DONE, vec_valid and busy SHALL be 0 and {a,b,c,d} SHALL be 0000.
REQ-017 hold=1 in RUN SHALL freeze the counter, idx, outputs and captures; a sample due on a held cycle is deferred to the first non-held cycle at count DWELL-1.
REQ-018 hold SHALL have no effect in IDLE or DONE.
REQ-019 start SHALL be ignored in RUN and DONE; no restart occurs and no error is flagged.
REQ-020 tt_f1 and tt_f2 SHALL retain their values after done until the next accepted start.
REQ-021 With DWELL=1, each vector SHALL last one cycle and be sampled in that same cycle.

Reset
REQ-022 rst_n=0 SHALL immediately force IDLE, with idx=0, counter=0, a=b=c=d=0, vec_valid=0, busy=0, done=0, tt_f1=16'h0000 and tt_f2=16'h0000, regardless of clk.
REQ-023 Reset asserted mid-RUN SHALL abort the sweep with no done pulse; after release, a new start is required.

Configuration
REQ-024 Macro TT_CAPTURE_EN SHALL control response capture.
- Defined: capture operates per REQ-014.
- Undefined: no capture registers exist, tt_f1 and tt_f2 are constant 16'h0000, and f1_in and f2_in are unused.
- Stimulus sequencing, timing and done are identical in both builds.

Verification
REQ-025 DWELL=20, TT_CAPTURE_EN defined, f1_in=a&b, f2_in=c|d, start pulsed 1 cycle -> done at 320 cycles after start acceptance, tt_f1=16'hF000, tt_f2=16'hEEEE.
REQ-026 DWELL=1, f1_in=a^b^c^d -> vectors 0..15 in 16 consecutive cycles, tt_f1=16'h6996.
REQ-027 DWELL=4, hold high for 10 cycles during vector 5 -> sweep takes 74 cycles, and vector 5 is on a..d for 14 cycles.
REQ-028 rst_n pulled low for a partial cycle during vector 9 -> all outputs 0 immediately, no done pulse, and a later start yields a full 16-vector sweep.
REQ-029 start held high through RUN and DONE -> exactly one sweep per acceptance; a new sweep starts on the cycle after DONE, with tt_f1 and tt_f2 cleared.
REQ-030 TT_CAPTURE_EN undefined, same stimulus as REQ-025 -> identical a..d, vec_valid and done timing, with tt_f1=tt_f2=16'h0000.
